// File: rtl/riscv_mem_arbiter_if.sv
// Signal bundle between fetch unit, LSU, memory port and riscv_mem_arbiter.
// slave = arbiter side, master = environment (requesters + memory) side.
interface riscv_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  // Instruction-fetch requester
  logic              i_if_req;
  logic [ADDR_W-1:0] i_if_addr;
  logic              o_if_gnt;
  logic              o_if_rvalid;
  logic [DATA_W-1:0] o_if_rdata;
  logic              o_if_err;

  // Load/store requester
  logic              i_d_req;
  logic              i_d_we;
  logic [ADDR_W-1:0] i_d_addr;
  logic [DATA_W-1:0] i_d_wdata;
  logic [BE_W-1:0]   i_d_be;
  logic              o_d_gnt;
  logic              o_d_rvalid;
  logic [DATA_W-1:0] o_d_rdata;
  logic              o_d_err;

  // Shared memory port
  logic              o_m_req;
  logic              o_m_we;
  logic [ADDR_W-1:0] o_m_addr;
  logic [DATA_W-1:0] o_m_wdata;
  logic [BE_W-1:0]   o_m_be;
  logic              i_m_gnt;
  logic              i_m_rvalid;
  logic [DATA_W-1:0] i_m_rdata;

  modport slave (
    input  i_if_req, i_if_addr,
    output o_if_gnt, o_if_rvalid, o_if_rdata, o_if_err,
    input  i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_be,
    output o_d_gnt, o_d_rvalid, o_d_rdata, o_d_err,
    output o_m_req, o_m_we, o_m_addr, o_m_wdata, o_m_be,
    input  i_m_gnt, i_m_rvalid, i_m_rdata
  );

  modport master (
    output i_if_req, i_if_addr,
    input  o_if_gnt, o_if_rvalid, o_if_rdata, o_if_err,
    output i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_be,
    input  o_d_gnt, o_d_rvalid, o_d_rdata, o_d_err,
    input  o_m_req, o_m_we, o_m_addr, o_m_wdata, o_m_be,
    output i_m_gnt, i_m_rvalid, i_m_rdata
  );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Two-requester memory arbiter: LSU has priority, fetch is guaranteed a slot after
// STARVE_MAX consecutive data grants; one outstanding transaction with a response timeout.
module riscv_mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 2,
  parameter int unsigned TIMEOUT    = 16
) (
  input logic              clk,
  input logic              rst,
  riscv_mem_arbiter_if.slave bus
);
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned STRK_W = $clog2(STARVE_MAX + 1);
  localparam int unsigned CNT_W  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e              state_q,     state_d;
  logic                own_lsu_q,   own_lsu_d;
  logic [STRK_W-1:0]   streak_q,    streak_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;

  logic                if_rvalid_q, if_rvalid_d;
  logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
  logic                if_err_q,    if_err_d;
  logic                d_rvalid_q,  d_rvalid_d;
  logic [DATA_W-1:0]   d_rdata_q,   d_rdata_d;
  logic                d_err_q,     d_err_d;

  logic                m_req_q,     m_req_d;
  logic                m_we_q,      m_we_d;
  logic [ADDR_W-1:0]   m_addr_q,    m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q,   m_wdata_d;
  logic [BE_W-1:0]     m_be_q,      m_be_d;

  logic                any_req_c;
  logic                if_win_c;
  logic                idle_c;
  logic                rsp_fire_c;
  logic                rsp_err_c;
  logic [DATA_W-1:0]   rsp_data_c;

  // Fetch wins only when data is absent or the data streak has hit its limit
  assign any_req_c = bus.i_if_req | bus.i_d_req;
  assign if_win_c  = bus.i_if_req & (~bus.i_d_req | (streak_q == STRK_W'(STARVE_MAX)));
  assign idle_c    = ~rst & (state_q == S_IDLE);

  assign bus.o_if_gnt = idle_c & if_win_c;
  assign bus.o_d_gnt  = idle_c & bus.i_d_req & ~if_win_c;

  assign bus.o_if_rvalid = if_rvalid_q;
  assign bus.o_if_rdata  = if_rdata_q;
  assign bus.o_if_err    = if_err_q;
  assign bus.o_d_rvalid  = d_rvalid_q;
  assign bus.o_d_rdata   = d_rdata_q;
  assign bus.o_d_err     = d_err_q;
  assign bus.o_m_req     = m_req_q;
  assign bus.o_m_we      = m_we_q;
  assign bus.o_m_addr    = m_addr_q;
  assign bus.o_m_wdata   = m_wdata_q;
  assign bus.o_m_be      = m_be_q;

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    own_lsu_d   = own_lsu_q;
    streak_d    = streak_q;
    cnt_d       = cnt_q;
    if_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    if_err_d    = 1'b0;
    d_rvalid_d  = 1'b0;
    d_rdata_d   = d_rdata_q;
    d_err_d     = 1'b0;
    m_req_d     = m_req_q;
    m_we_d      = m_we_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    m_be_d      = m_be_q;
    rsp_fire_c  = 1'b0;
    rsp_err_c   = 1'b0;
    rsp_data_c  = '0;

    case (state_q)
      S_IDLE: begin
        if (any_req_c) begin
          state_d = S_REQ;
          m_req_d = 1'b1;
          if (if_win_c) begin
            own_lsu_d = 1'b0;
            streak_d  = '0;
            m_we_d    = 1'b0;
            m_addr_d  = bus.i_if_addr;
            m_wdata_d = '0;
            m_be_d    = '1;
          end else begin
            own_lsu_d = 1'b1;
            m_we_d    = bus.i_d_we;
            m_addr_d  = bus.i_d_addr;
            m_wdata_d = bus.i_d_wdata;
            m_be_d    = bus.i_d_be;
            if (!bus.i_if_req) begin
              streak_d = '0;
            end else if (streak_q != STRK_W'(STARVE_MAX)) begin
              streak_d = streak_q + STRK_W'(1);
            end
          end
        end
      end

      S_REQ: begin
        if (bus.i_m_gnt) begin
          m_req_d = 1'b0;
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (bus.i_m_rvalid) begin
          rsp_fire_c = 1'b1;
          rsp_data_c = bus.i_m_rdata;
          state_d    = S_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rsp_fire_c = 1'b1;
          rsp_err_c  = 1'b1;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Route the response only to the transaction owner
    if (rsp_fire_c) begin
      if (own_lsu_q) begin
        d_rvalid_d = 1'b1;
        d_rdata_d  = rsp_data_c;
        d_err_d    = rsp_err_c;
      end else begin
        if_rvalid_d = 1'b1;
        if_rdata_d  = rsp_data_c;
        if_err_d    = rsp_err_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      own_lsu_q   <= 1'b0;
      streak_q    <= '0;
      cnt_q       <= '0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      if_err_q    <= 1'b0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= '0;
      d_err_q     <= 1'b0;
      m_req_q     <= 1'b0;
      m_we_q      <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      m_be_q      <= '0;
    end else begin
      state_q     <= state_d;
      own_lsu_q   <= own_lsu_d;
      streak_q    <= streak_d;
      cnt_q       <= cnt_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      if_err_q    <= if_err_d;
      d_rvalid_q  <= d_rvalid_d;
      d_rdata_q   <= d_rdata_d;
      d_err_q     <= d_err_d;
      m_req_q     <= m_req_d;
      m_we_q      <= m_we_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      m_be_q      <= m_be_d;
    end
  end
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Bench for riscv_mem_arbiter: directed scenarios then random traffic, every cycle
// compared against a transaction-level reference model of the arbiter.
module tb_riscv_mem_arbiter;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned STARVE_MAX = 2;
  localparam int unsigned TIMEOUT    = 16;

  logic clk;
  logic rst;

  riscv_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  riscv_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;
  int cyc;

  // Requester-side stimulus state
  bit          if_pend, d_pend;
  logic [31:0] if_addr_s, d_addr_s, d_wdata_s;
  logic        d_we_s;
  logic [3:0]  d_be_s;
  int          p_if, p_d, p_stray, p_to;
  int          gd_min, gd_max, rd_min, rd_max;
  bit          fix_data;
  logic [31:0] fix_val;
  bit          do_rst;

  // Reference model: one outstanding transaction described by flags and ages
  bit          busy, accepted, own_lsu;
  int          age, gd_cur, rd_cur, streak;
  bit          e_if_rv, e_if_err, e_d_rv, e_d_err;
  logic [31:0] e_if_rdata, e_d_rdata;
  bit          e_m_req, e_m_we;
  logic [31:0] e_m_addr, e_m_wdata;
  logic [3:0]  e_m_be;

  // Observations
  bit glog[$];
  int rv_cnt, mreq_cnt;
  int last_if_gnt_cyc, last_rv_cyc, last_mgnt_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    busy = 0; accepted = 0; own_lsu = 0; age = 0; streak = 0;
    e_if_rv = 0; e_if_err = 0; e_if_rdata = '0;
    e_d_rv = 0; e_d_err = 0; e_d_rdata = '0;
    e_m_req = 0; e_m_we = 0; e_m_addr = '0; e_m_wdata = '0; e_m_be = '0;
  endtask

  task automatic respond(input logic [31:0] data, input bit err);
    if (own_lsu) begin e_d_rv = 1; e_d_rdata = data; e_d_err = err; end
    else begin e_if_rv = 1; e_if_rdata = data; e_if_err = err; end
    busy = 0;
  endtask

  // One clock cycle: drive, check, advance the model
  task automatic step();
    bit mg, mr, any, win_if;
    logic [31:0] md;
    @(posedge clk);
    #1;
    cyc++;
    if (!if_pend && p_if > 0 && int'($urandom_range(99)) < p_if) begin
      if_pend = 1; if_addr_s = $urandom;
    end
    if (!d_pend && p_d > 0 && int'($urandom_range(99)) < p_d) begin
      d_pend = 1; d_addr_s = $urandom; d_wdata_s = $urandom;
      d_we_s = 1'($urandom); d_be_s = 4'($urandom);
    end
    mg = 0; mr = 0;
    md = fix_data ? fix_val : $urandom;
    if (busy && !accepted) mg = (age == gd_cur);
    else if (busy) mr = (rd_cur >= 0 && age == rd_cur);
    else mr = (p_stray > 0 && int'($urandom_range(99)) < p_stray);

    rst            = do_rst;
    bus.i_if_req   = if_pend;
    bus.i_if_addr  = if_addr_s;
    bus.i_d_req    = d_pend;
    bus.i_d_we     = d_we_s;
    bus.i_d_addr   = d_addr_s;
    bus.i_d_wdata  = d_wdata_s;
    bus.i_d_be     = d_be_s;
    bus.i_m_gnt    = mg;
    bus.i_m_rvalid = mr;
    bus.i_m_rdata  = md;
    #1;

    any    = if_pend || d_pend;
    win_if = if_pend && (!d_pend || streak == int'(STARVE_MAX));
    chk("if_gnt",    64'(bus.o_if_gnt),    64'(!do_rst && !busy && win_if));
    chk("d_gnt",     64'(bus.o_d_gnt),     64'(!do_rst && !busy && any && !win_if));
    chk("if_rvalid", 64'(bus.o_if_rvalid), 64'(e_if_rv));
    chk("if_err",    64'(bus.o_if_err),    64'(e_if_err));
    chk("if_rdata",  64'(bus.o_if_rdata),  64'(e_if_rdata));
    chk("d_rvalid",  64'(bus.o_d_rvalid),  64'(e_d_rv));
    chk("d_err",     64'(bus.o_d_err),     64'(e_d_err));
    chk("d_rdata",   64'(bus.o_d_rdata),   64'(e_d_rdata));
    chk("m_req",     64'(bus.o_m_req),     64'(e_m_req));
    chk("m_we",      64'(bus.o_m_we),      64'(e_m_we));
    chk("m_addr",    64'(bus.o_m_addr),    64'(e_m_addr));
    chk("m_wdata",   64'(bus.o_m_wdata),   64'(e_m_wdata));
    chk("m_be",      64'(bus.o_m_be),      64'(e_m_be));

    if (bus.o_if_gnt === 1'b1) begin glog.push_back(1'b1); last_if_gnt_cyc = cyc; end
    if (bus.o_d_gnt === 1'b1) glog.push_back(1'b0);
    if (bus.o_if_rvalid === 1'b1 || bus.o_d_rvalid === 1'b1) begin rv_cnt++; last_rv_cyc = cyc; end
    if (bus.o_m_req === 1'b1) mreq_cnt++;
    if (mg) last_mgnt_cyc = cyc;

    e_if_rv = 0; e_if_err = 0; e_d_rv = 0; e_d_err = 0;
    if (do_rst) begin
      model_reset();
    end else if (!busy) begin
      if (any) begin
        busy = 1; accepted = 0; age = 0; e_m_req = 1;
        gd_cur = int'($urandom_range(gd_max, gd_min));
        rd_cur = (p_to > 0 && int'($urandom_range(99)) < p_to) ? -1
                 : int'($urandom_range(rd_max, rd_min));
        if (win_if) begin
          own_lsu = 0; streak = 0; if_pend = 0;
          e_m_we = 0; e_m_addr = if_addr_s; e_m_wdata = '0; e_m_be = 4'hF;
        end else begin
          own_lsu = 1; d_pend = 0;
          streak = if_pend ? ((streak < int'(STARVE_MAX)) ? streak + 1 : streak) : 0;
          e_m_we = d_we_s; e_m_addr = d_addr_s; e_m_wdata = d_wdata_s; e_m_be = d_be_s;
        end
      end
    end else if (!accepted) begin
      if (mg) begin accepted = 1; age = 0; e_m_req = 0; end
      else age++;
    end else begin
      if (mr) respond(md, 0);
      else if (age == int'(TIMEOUT) - 1) respond('0, 1);
      else age++;
    end
  endtask

  // Step until the model is idle with nothing pending, then one more cycle for the response
  task automatic run_idle(input int max);
    int n;
    n = 0;
    while ((busy || if_pend || d_pend) && n < max) begin
      step();
      n++;
    end
    checks++;
    assert (n < max) else begin
      failures++;
      $error("FAIL drain_bound observed=%0d expected_below=%0d", n, max);
    end
    step();
  endtask

  task automatic set_mem(input int g0, input int g1, input int r0, input int r1, input int pto);
    gd_min = g0; gd_max = g1; rd_min = r0; rd_max = r1; p_to = pto;
  endtask

  initial begin
    int n;
    checks = 0; failures = 0; cyc = 0;
    rst = 1; do_rst = 1;
    if_pend = 0; d_pend = 0; if_addr_s = '0; d_addr_s = '0; d_wdata_s = '0;
    d_we_s = 0; d_be_s = '0;
    p_if = 0; p_d = 0; p_stray = 0; fix_data = 0; fix_val = '0;
    set_mem(0, 0, 0, 0, 0);
    gd_cur = 0; rd_cur = 0;
    rv_cnt = 0; mreq_cnt = 0; last_if_gnt_cyc = 0; last_rv_cyc = 0; last_mgnt_cyc = 0;
    bus.i_if_req = 0; bus.i_if_addr = '0; bus.i_d_req = 0; bus.i_d_we = 0;
    bus.i_d_addr = '0; bus.i_d_wdata = '0; bus.i_d_be = '0;
    bus.i_m_gnt = 0; bus.i_m_rvalid = 0; bus.i_m_rdata = '0;
    model_reset();

    // Reset values
    step(); step();
    do_rst = 0;

    // Single fetch with best-case memory latency
    set_mem(0, 0, 0, 0, 0);
    fix_data = 1; fix_val = 32'hDEAD_BEEF;
    if_pend = 1; if_addr_s = 32'h100; rv_cnt = 0;
    run_idle(20);
    chk("fetch_latency", 64'(last_rv_cyc - last_if_gnt_cyc), 64'd3);
    chk("fetch_rsp_count", 64'(rv_cnt), 64'd1);
    fix_data = 0;

    // Data write
    set_mem(0, 0, 1, 1, 0);
    d_pend = 1; d_addr_s = 32'h200; d_wdata_s = 32'h1234_5678; d_we_s = 1; d_be_s = 4'b0011;
    rv_cnt = 0;
    run_idle(20);
    chk("dwrite_rsp_count", 64'(rv_cnt), 64'd1);

    // Starvation: both requesters saturated
    set_mem(0, 0, 0, 0, 0);
    glog.delete();
    p_if = 100; p_d = 100;
    repeat (30) step();
    p_if = 0; p_d = 0;
    chk("starve_grants_seen", 64'(glog.size() >= 9), 64'd1);
    for (int k = 0; k < 9 && k < glog.size(); k++)
      chk("starve_order", 64'(glog[k]), 64'((k % (STARVE_MAX + 1)) == STARVE_MAX));
    run_idle(20);

    // Memory stall: grant after 4 cycles, response after 5
    set_mem(4, 4, 5, 5, 0);
    d_pend = 1; d_addr_s = $urandom; d_wdata_s = $urandom; d_we_s = 0; d_be_s = 4'hF;
    mreq_cnt = 0;
    run_idle(40);
    chk("stall_mreq_cycles", 64'(mreq_cnt), 64'd5);

    // Timeout, then stray rvalid in IDLE
    set_mem(0, 0, 0, 0, 100);
    d_pend = 1; d_addr_s = $urandom; d_we_s = 0; d_be_s = 4'hF;
    run_idle(40);
    chk("timeout_latency", 64'(last_rv_cyc - (last_mgnt_cyc + 1)), 64'(TIMEOUT));
    p_stray = 100; rv_cnt = 0;
    repeat (6) step();
    chk("stray_rvalid_quiet", 64'(rv_cnt), 64'd0);
    p_stray = 0;

    // Reset while waiting for the memory
    set_mem(0, 0, 0, 0, 100);
    if_pend = 1; if_addr_s = $urandom;
    n = 0;
    while (!(busy && accepted) && n < 20) begin step(); n++; end
    checks++;
    assert (n < 20) else begin
      failures++;
      $error("FAIL reach_wait_bound observed=%0d expected_below=20", n);
    end
    step(); step();
    do_rst = 1; step(); do_rst = 0;
    rv_cnt = 0;
    repeat (20) step();
    chk("reset_no_rsp", 64'(rv_cnt), 64'd0);
    set_mem(0, 0, 0, 0, 0);
    if_pend = 1; if_addr_s = $urandom; rv_cnt = 0;
    run_idle(20);
    chk("post_reset_fetch", 64'(rv_cnt), 64'd1);

    // Random mixed traffic
    set_mem(0, 3, 0, 6, 8);
    p_if = 35; p_d = 45; p_stray = 15;
    repeat (1500) step();
    p_if = 0; p_d = 0; p_stray = 0;
    run_idle(80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/riscv_mem_arbiter.md
# riscv_mem_arbiter

Two-requester memory arbiter for the verilog_riscv core. It shares a single memory port between the instruction-fetch unit and the load/store unit. Data requests have priority, with a bounded anti-starvation rule that guarantees fetch progress. At most one transaction is outstanding at a time, and a response timeout prevents the core from hanging on a dead memory.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte enables are DATA_W/8 wide
- STARVE_MAX, 2, consecutive data grants allowed while fetch is pending (≥1)
- TIMEOUT, 16, maximum cycles in WAIT before an error response (≥2)
- clk  in  1  clock; all logic is rising-edge
- rst  in  1  reset, synchronous, active-high
- i_if_req  in  1  fetch request; held with i_if_addr until o_if_gnt
- i_if_addr  in  ADDR_W  fetch address
- o_if_gnt  out  1  fetch request accepted (1-cycle pulse)
- o_if_rvalid  out  1  fetch response valid (1-cycle pulse)
- o_if_rdata  out  DATA_W  fetch read data
- o_if_err  out  1  fetch response is a timeout error, qualified by o_if_rvalid
- i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_be  in  1/1/ADDR_W/DATA_W/DATA_W/8  LSU request, held until o_d_gnt
- o_d_gnt, o_d_rvalid, o_d_rdata, o_d_err  out  1/1/DATA_W/1  LSU counterparts of the fetch outputs; a write also returns one rvalid
- o_m_req, o_m_we, o_m_addr, o_m_wdata, o_m_be  out  memory request; all registered, held until i_m_gnt
- i_m_gnt  in  1  memory accepts request
- i_m_rvalid, i_m_rdata  in  1/DATA_W  memory response

## Operation
- States: IDLE, REQ, WAIT.
- **IDLE**
  - If any request is asserted, pick a winner, pulse its o_x_gnt (combinational from state and requests), latch the winner's id and fields into the o_m_* registers, and go to REQ.
  - With no requests, stay in IDLE.
- **Arbitration**
  - Data wins, except fetch wins when i_if_req=1 and streak==STARVE_MAX.
  - streak is a saturating counter. It increments on a data grant while i_if_req=1, clears on any fetch grant, and clears on a data grant with i_if_req=0.
- **REQ**
  - o_m_req=1 with stable fields.
  - On i_m_gnt, drop o_m_req and go to WAIT with the timeout counter cleared.
- **WAIT**
  - The counter increments each cycle.
  - On i_m_rvalid, register rdata to the owner's o_x_rdata, pulse o_x_rvalid with o_x_err=0, and go to IDLE.
  - If the counter reaches TIMEOUT-1 without i_m_rvalid, pulse the owner's o_x_rvalid with o_x_err=1 and o_x_rdata=0, and go to IDLE.
- **Response routing**
  - Only the owner's rvalid pulses.
  - The other requester's rdata holds its previous value.
- i_m_rvalid outside WAIT is ignored; no state change, no output.
- Fetch requests always drive o_m_we=0, o_m_be=all-ones, o_m_wdata=0.

## Timing
- **Reset values:** every gnt, rvalid, err and o_m_req is 0; all rdata, o_m_addr, o_m_wdata, o_m_be and o_m_we are 0. State=IDLE, streak=0, counter=0.
- **Reset mid-transaction:** effective at the next edge. o_m_req drops and no response is issued for the aborted transaction.
- **Best-case latency**, with the memory granting in the first REQ cycle and responding in the first WAIT cycle:
  - cycle 0: request and gnt
  - cycle 1: REQ, m_gnt
  - cycle 2: WAIT, m_rvalid
  - cycle 3: o_x_rvalid
- The cycle with o_x_rvalid is an IDLE cycle, so a new grant can issue in that same cycle. Back-to-back throughput is one transaction per 3 cycles.
- The memory must not assert i_m_rvalid in the same cycle as i_m_gnt.
- A timeout rvalid appears TIMEOUT cycles after entering WAIT.
- A requester may deassert its request only after gnt. Request changes before gnt are legal and re-evaluated each IDLE cycle.
- When both requests arrive in the same IDLE cycle, exactly one gnt pulses and the loser stays pending.

## Test plan
- **Single fetch:** fetch at addr 0x100 with memory data 0xDEADBEEF at 1-cycle latency → o_if_gnt in cycle 0, o_m_addr=0x100 with o_m_req in cycle 1, o_if_rvalid with rdata 0xDEADBEEF in cycle 3, err=0, o_d_rvalid stays 0.
- **Data write:** addr 0x200, wdata 0x12345678, be=4'b0011 → o_m_we=1 and fields match on o_m_*; one o_d_rvalid pulse.
- **Starvation:** both requests held continuously with STARVE_MAX=2 → grant order D, D, F, D, D, F…; streak clears after each F.
- **Memory stall:** i_m_gnt delayed 4 cycles, then i_m_rvalid delayed 5 → o_m_req held constant for 5 cycles; the response is correct and err=0.
- **Timeout:** i_m_rvalid never asserted, TIMEOUT=16 → o_d_rvalid=1, o_d_err=1, rdata=0 exactly 16 cycles after WAIT entry. A stray i_m_rvalid afterwards in IDLE produces no output.
- **Reset in WAIT:** rst pulsed for 1 cycle → all outputs 0 the next cycle, state IDLE, no rvalid for the aborted request; a subsequent fetch completes normally.
